// File: rtl/rgb2ycbcr_pipe_if.sv
// Video stream bundle for rgb2ycbcr_pipe: RGB input framing, matrix select,
// and the converted Y/Cb/Cr output with its pixel/line coordinates.
interface rgb2ycbcr_pipe_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 12
);
    logic             per_img_vsync;
    logic             per_img_herf;
    logic             per_img_valid;
    logic [DW-1:0]    per_img_red;
    logic [DW-1:0]    per_img_green;
    logic [DW-1:0]    per_img_blue;
    logic [1:0]       cfg_mode;

    logic             post_img_vsync;
    logic             post_img_herf;
    logic             post_img_valid;
    logic [DW-1:0]    post_img_Y;
    logic [DW-1:0]    post_img_Cb;
    logic [DW-1:0]    post_img_Cr;
    logic [CNT_W-1:0] post_img_x;
    logic [CNT_W-1:0] post_img_y;

    modport master (
        output per_img_vsync, per_img_herf, per_img_valid,
        output per_img_red, per_img_green, per_img_blue, cfg_mode,
        input  post_img_vsync, post_img_herf, post_img_valid,
        input  post_img_Y, post_img_Cb, post_img_Cr, post_img_x, post_img_y
    );

    modport slave (
        input  per_img_vsync, per_img_herf, per_img_valid,
        input  per_img_red, per_img_green, per_img_blue, cfg_mode,
        output post_img_vsync, post_img_herf, post_img_valid,
        output post_img_Y, post_img_Cb, post_img_Cr, post_img_x, post_img_y
    );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// 3-stage RGB->YCbCr converter (BT.601 full/studio, BT.709 studio) with output coordinates.
// Optional 4:2:2 co-sited chroma when YCBCR_422_OUT_EN is defined.
module rgb2ycbcr_pipe #(
    parameter int DW    = 8,
    parameter int CNT_W = 12
) (
    input logic             clk,
    input logic             rst,
    rgb2ycbcr_pipe_if.slave vid
);
    localparam int PW = DW + 10;
    localparam int SW = DW + 12;
    localparam logic signed [SW-1:0] RND     = SW'(128);
    localparam logic signed [SW-1:0] MAXV    = SW'((1 << DW) - 1);
    localparam logic signed [SW-1:0] C_OFF   = SW'(1 << (DW - 1));
    localparam logic signed [SW-1:0] Y_OFF_S = SW'(16 << (DW - 8));

    typedef enum logic [1:0] {
        MODE_601_FULL   = 2'd0,
        MODE_601_STUDIO = 2'd1,
        MODE_709_STUDIO = 2'd2
    } mode_t;

    mode_t mode_q, mode_sel, mode_eff, mode1, mode2;
    logic  vs_prev, armed, vs_rise, pass;

    logic signed [8:0]    k    [9];
    logic signed [PW-1:0] op   [3];
    logic signed [PW-1:0] prod [9];
    logic signed [SW-1:0] sum  [3];
    logic signed [SW-1:0] y_off;
    logic [2:0]           vs_d, hf_d, v_d;

    logic [DW-1:0]    y_q, cb_q, cr_q;
    logic [CNT_W-1:0] x_q, yc_q, x_next, y_next;
    logic             vs_clr, hf_clr;

    // The pixel on the vsync-rise cycle already belongs to the new frame, so it
    // sees the freshly selected matrix rather than the latched one.
    always_comb begin
        vs_rise = vid.per_img_vsync & ~vs_prev;
        pass    = armed | vs_rise;
        case (vid.cfg_mode)
            2'd1:    mode_sel = MODE_601_STUDIO;
            2'd2:    mode_sel = MODE_709_STUDIO;
            default: mode_sel = MODE_601_FULL;
        endcase
        mode_eff = vs_rise ? mode_sel : mode_q;
    end

    always_comb begin
        case (mode_eff)
            MODE_601_STUDIO: k = '{9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112,
                                   9'sd112, -9'sd94, -9'sd18};
            MODE_709_STUDIO: k = '{9'sd47, 9'sd157, 9'sd16, -9'sd26, -9'sd87, 9'sd112,
                                   9'sd112, -9'sd102, -9'sd10};
            default:         k = '{9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128,
                                   9'sd128, -9'sd107, -9'sd21};
        endcase
        op[0] = $signed(PW'(vid.per_img_red));
        op[1] = $signed(PW'(vid.per_img_green));
        op[2] = $signed(PW'(vid.per_img_blue));
    end

    // vs_prev resets high so a frame already in progress at reset release is
    // not mistaken for a fresh vsync rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev <= 1'b1;
            armed   <= 1'b0;
            mode_q  <= MODE_601_FULL;
        end else begin
            vs_prev <= vid.per_img_vsync;
            if (vs_rise) begin
                armed  <= 1'b1;
                mode_q <= mode_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 9; i++) prod[i] <= '0;
            for (int unsigned r = 0; r < 3; r++) sum[r] <= '0;
            vs_d  <= '0;
            hf_d  <= '0;
            v_d   <= '0;
            mode1 <= MODE_601_FULL;
            mode2 <= MODE_601_FULL;
        end else begin
            for (int unsigned i = 0; i < 9; i++) prod[i] <= op[i % 3] * PW'(k[i]);
            for (int unsigned r = 0; r < 3; r++)
                sum[r] <= SW'(prod[3*r]) + SW'(prod[3*r+1]) + SW'(prod[3*r+2]);
            vs_d  <= {vs_d[1:0], vid.per_img_vsync & pass};
            hf_d  <= {hf_d[1:0], vid.per_img_herf & pass};
            v_d   <= {v_d[1:0], vid.per_img_valid & pass};
            mode1 <= mode_eff;
            mode2 <= mode1;
        end
    end

    function automatic logic [DW-1:0] scale_clamp(input logic signed [SW-1:0] s,
                                                  input logic signed [SW-1:0] off);
        logic signed [SW-1:0] t;
        logic [DW-1:0]        res;
        t = ((s + RND) >>> 8) + off;
        if (t < 0)         res = '0;
        else if (t > MAXV) res = '1;
        else               res = t[DW-1:0];
        return res;
    endfunction

    // Counter updates look one stage ahead so x/y already describe the pixel
    // that is being loaded into the output registers.
    always_comb begin
        y_off  = (mode2 == MODE_601_FULL) ? '0 : Y_OFF_S;
        vs_clr = vs_d[1] & ~vs_d[2];
        hf_clr = hf_d[2] & ~hf_d[1];
        x_next = x_q;
        y_next = yc_q;
        if (vs_clr) begin
            x_next = '0;
            y_next = '0;
        end else if (hf_clr) begin
            x_next = '0;
            y_next = yc_q + 1'b1;
        end else if (v_d[2]) begin
            x_next = x_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q  <= '0;
            cb_q <= '0;
            cr_q <= '0;
            x_q  <= '0;
            yc_q <= '0;
        end else begin
            x_q  <= x_next;
            yc_q <= y_next;
            if (v_d[1]) begin
                y_q <= scale_clamp(sum[0], y_off);
`ifdef YCBCR_422_OUT_EN
                // Odd pixels leave the chroma registers alone, so they repeat the even pixel.
                if (!x_next[0]) begin
                    cb_q <= scale_clamp(sum[1], C_OFF);
                    cr_q <= scale_clamp(sum[2], C_OFF);
                end
`else
                cb_q <= scale_clamp(sum[1], C_OFF);
                cr_q <= scale_clamp(sum[2], C_OFF);
`endif
            end
        end
    end

    assign vid.post_img_vsync = vs_d[2];
    assign vid.post_img_herf  = hf_d[2];
    assign vid.post_img_valid = v_d[2];
    assign vid.post_img_Y     = y_q;
    assign vid.post_img_Cb    = cb_q;
    assign vid.post_img_Cr    = cr_q;
    assign vid.post_img_x     = x_q;
    assign vid.post_img_y     = yc_q;
endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Self-checking bench for rgb2ycbcr_pipe: directed literal checks plus random
// frames compared every cycle against a queue-based frame/pixel model.
module tb_rgb2ycbcr_pipe;
    localparam int DW    = 8;
    localparam int CNT_W = 12;
    localparam int MAXC  = (1 << DW) - 1;
    localparam int K [3][9] = '{
        '{77, 150, 29, -43, -85, 128, 128, -107, -21},
        '{66, 129, 25, -38, -74, 112, 112, -94, -18},
        '{47, 157, 16, -26, -87, 112, 112, -102, -10}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb2ycbcr_pipe_if #(.DW(DW), .CNT_W(CNT_W)) vid ();
    rgb2ycbcr_pipe #(.DW(DW), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .vid(vid));

    typedef struct {
        bit vs, hf, v;
        int y, cb, cr;
    } ent_t;

    ent_t q[$];
    ent_t o, zero_e;
    int   ex_y, ex_cb, ex_cr, ex_x, ex_yc;
    bit   m_armed, m_prev_vs;
    int   m_mode;
    int   n_cmp = 0, n_bad = 0;
    bit   chk_en = 0;
    int   cm;

    function automatic int conv(input int mode, input int row, input int r, input int g, input int b);
        int m, s, off;
        m   = (mode == 3) ? 0 : mode;
        s   = K[m][row*3] * r + K[m][row*3+1] * g + K[m][row*3+2] * b;
        off = (row != 0) ? (1 << (DW - 1)) : ((m == 0) ? 0 : (16 << (DW - 8)));
        s   = ((s + 128) >>> 8) + off;
        if (s < 0) s = 0;
        if (s > MAXC) s = MAXC;
        return s;
    endfunction

    function automatic int rc();
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? MAXC : 0;
        return int'($urandom_range(0, MAXC));
    endfunction

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    // One clock of stimulus; the model tracks frame arming, the frame's matrix,
    // a 3-cycle output queue, held data and the x/y coordinate rules.
    task automatic step(input bit r_st, input bit vs, input bit hf, input bit v,
                        input int r, input int g, input int b, input int mode);
        ent_t e, n;
        bit   rise;
        rst = r_st;
        vid.per_img_vsync = vs;
        vid.per_img_herf  = hf;
        vid.per_img_valid = v;
        vid.per_img_red   = DW'(r);
        vid.per_img_green = DW'(g);
        vid.per_img_blue  = DW'(b);
        vid.cfg_mode      = 2'(mode);
        e = zero_e;
        if (r_st) begin
            m_armed = 0; m_prev_vs = 1; m_mode = 0;
            q.delete();
            q.push_back(zero_e);
            q.push_back(zero_e);
        end else begin
            rise = vs && !m_prev_vs;
            m_prev_vs = vs;
            if (rise) begin
                m_armed = 1;
                m_mode = (mode == 3) ? 0 : mode;
            end
            if (m_armed) begin
                e.vs = vs; e.hf = hf; e.v = v;
                e.y  = conv(m_mode, 0, r, g, b);
                e.cb = conv(m_mode, 1, r, g, b);
                e.cr = conv(m_mode, 2, r, g, b);
            end
        end
        q.push_back(e);
        @(posedge clk);
        n = q.pop_front();
        if (r_st) begin
            o = zero_e;
            ex_y = 0; ex_cb = 0; ex_cr = 0; ex_x = 0; ex_yc = 0;
        end else begin
            if (!o.vs && n.vs) begin
                ex_x = 0; ex_yc = 0;
            end else if (o.hf && !n.hf) begin
                ex_x = 0; ex_yc = (ex_yc + 1) % (1 << CNT_W);
            end else if (o.v) begin
                ex_x = (ex_x + 1) % (1 << CNT_W);
            end
            if (n.v) begin
                ex_y = n.y;
`ifdef YCBCR_422_OUT_EN
                if (ex_x % 2 == 0) begin
                    ex_cb = n.cb; ex_cr = n.cr;
                end
`else
                ex_cb = n.cb; ex_cr = n.cr;
`endif
            end
            o = n;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (vid.post_img_vsync !== o.vs || vid.post_img_herf !== o.hf ||
                vid.post_img_valid !== o.v || vid.post_img_Y !== DW'(ex_y) ||
                vid.post_img_Cb !== DW'(ex_cb) || vid.post_img_Cr !== DW'(ex_cr) ||
                vid.post_img_x !== CNT_W'(ex_x) || vid.post_img_y !== CNT_W'(ex_yc)) begin
                n_bad++;
                $display("FAIL cycle @%0t: got vs/hf/v=%b%b%b Y/Cb/Cr=%0d/%0d/%0d x/y=%0d/%0d, required %b%b%b %0d/%0d/%0d %0d/%0d",
                         $time, vid.post_img_vsync, vid.post_img_herf, vid.post_img_valid,
                         vid.post_img_Y, vid.post_img_Cb, vid.post_img_Cr, vid.post_img_x,
                         vid.post_img_y, o.vs, o.hf, o.v, ex_y, ex_cb, ex_cr, ex_x, ex_yc);
            end
        end
    end

    task automatic px_chk(input string nm, input int r, input int g, input int b,
                          input int ey, input int ecb, input int ecr);
        step(0, 1, 1, 1, r, g, b, cm);
        step(0, 1, 1, 0, 0, 0, 0, cm);
        step(0, 1, 1, 0, 0, 0, 0, cm);
        lit({nm, "_valid"}, vid.post_img_valid, 1);
        lit({nm, "_Y"}, vid.post_img_Y, ey);
        lit({nm, "_Cb"}, vid.post_img_Cb, ecb);
        lit({nm, "_Cr"}, vid.post_img_Cr, ecr);
    endtask

    task automatic idle(input int n, input bit vs);
        for (int i = 0; i < n; i++) step(0, vs, 0, 0, 0, 0, 0, cm);
    endtask

    initial begin
        zero_e = '{vs: 0, hf: 0, v: 0, y: 0, cb: 0, cr: 0};
        o = zero_e;
        cm = 0;
        lit("model_red_Cb", conv(0, 1, MAXC, 0, 0), 85);
        lit("model_studio_white_Y", conv(1, 0, MAXC, MAXC, MAXC), 235);
        lit("model_green_Cr", conv(0, 2, 0, MAXC, 0), 21);
        lit("model_mode3_red_Y", conv(3, 0, MAXC, 0, 0), 77);

        chk_en = 1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        lit("reset_Y", vid.post_img_Y, 0);
        lit("reset_valid", vid.post_img_valid, 0);
        idle(3, 0);

        // Frame in BT.601 full range
        step(0, 1, 0, 0, 0, 0, 0, cm);
        px_chk("white601f", MAXC, MAXC, MAXC, 255, 128, 128);
        px_chk("black601f", 0, 0, 0, 0, 128, 128);
        px_chk("red601f", MAXC, 0, 0, 77, 85, 255);
        idle(2, 1);
        idle(3, 0);

        // Studio frame; a mid-frame switch to mode 0 must not take effect
        cm = 1;
        step(0, 1, 0, 0, 0, 0, 0, cm);
        px_chk("white601s", MAXC, MAXC, MAXC, 235, 128, 128);
        px_chk("black601s", 0, 0, 0, 16, 128, 128);
        cm = 0;
        px_chk("white_midswitch", MAXC, MAXC, MAXC, 235, 128, 128);
        idle(2, 1);
        idle(3, 0);
        step(0, 1, 0, 0, 0, 0, 0, cm);
        px_chk("white_nextframe", MAXC, MAXC, MAXC, 255, 128, 128);
        idle(3, 1);

        // Red, blue, green back to back on a fresh line
        step(0, 1, 1, 1, MAXC, 0, 0, cm);
        step(0, 1, 1, 1, 0, 0, MAXC, cm);
        step(0, 1, 1, 1, 0, MAXC, 0, cm);
        lit("seq_red_Cb", vid.post_img_Cb, 85);
        lit("seq_red_x", vid.post_img_x, 0);
        step(0, 1, 1, 0, 0, 0, 0, cm);
        lit("seq_blue_Y", vid.post_img_Y, 29);
`ifdef YCBCR_422_OUT_EN
        lit("seq_blue_Cb", vid.post_img_Cb, 85);
        lit("seq_blue_Cr", vid.post_img_Cr, 255);
`else
        lit("seq_blue_Cb", vid.post_img_Cb, 255);
        lit("seq_blue_Cr", vid.post_img_Cr, 107);
`endif
        step(0, 1, 1, 0, 0, 0, 0, cm);
        lit("seq_green_Y", vid.post_img_Y, 149);
        lit("seq_green_Cb", vid.post_img_Cb, 43);
        lit("seq_green_Cr", vid.post_img_Cr, 21);
        idle(2, 1);
        idle(3, 0);

        // 4 lines x 5 pixels with valid gaps
        step(0, 1, 0, 0, 0, 0, 0, cm);
        for (int l = 0; l < 4; l++) begin
            idle(2, 1);
            for (int p = 0; p < 5; p++) begin
                for (int gap = $urandom_range(0, 2); gap > 0; gap--)
                    step(0, 1, 1, 0, rc(), rc(), rc(), cm);
                step(0, 1, 1, 1, rc(), rc(), rc(), cm);
            end
            step(0, 1, 1, 0, 0, 0, 0, cm);
            step(0, 1, 1, 0, 0, 0, 0, cm);
            lit("line_last_x", vid.post_img_x, 4);
            lit("line_last_y", vid.post_img_y, l);
        end
        idle(2, 1);
        idle(2, 0);
        step(0, 1, 0, 0, 0, 0, 0, cm);
        idle(2, 1);
        lit("newframe_vsync", vid.post_img_vsync, 1);
        lit("newframe_x", vid.post_img_x, 0);
        lit("newframe_y", vid.post_img_y, 0);

        // Reset mid-line, then pixels keep arriving inside the aborted frame
        for (int p = 0; p < 3; p++) step(0, 1, 1, 1, rc(), rc(), rc(), cm);
        step(1, 1, 1, 1, rc(), rc(), rc(), cm);
        lit("midrst_valid", vid.post_img_valid, 0);
        lit("midrst_Y", vid.post_img_Y, 0);
        lit("midrst_x", vid.post_img_x, 0);
        for (int p = 0; p < 6; p++) step(0, 1, 1, 1, rc(), rc(), rc(), cm);
        lit("aborted_valid", vid.post_img_valid, 0);
        idle(2, 0);

        // Line still open when the next vsync rises: y must clear
        step(0, 1, 0, 0, 0, 0, 0, cm);
        step(0, 1, 1, 1, rc(), rc(), rc(), cm);
        step(0, 0, 1, 1, rc(), rc(), rc(), cm);
        step(0, 1, 0, 0, 0, 0, 0, cm);
        idle(2, 1);
        lit("vsrise_hffall_y", vid.post_img_y, 0);

        for (int f = 0; f < 8; f++) begin
            int nl, np;
            cm = int'($urandom_range(0, 3));
            idle(2, 0);
            step(0, 1, 0, 0, 0, 0, 0, cm);
            nl = int'($urandom_range(1, 4));
            for (int l = 0; l < nl; l++) begin
                np = int'($urandom_range(1, 8));
                for (int p = 0; p < np; p++) begin
                    for (int gap = $urandom_range(0, 2); gap > 0; gap--)
                        step(0, 1, 1, 0, rc(), rc(), rc(), int'($urandom_range(0, 3)));
                    step(0, 1, 1, 1, rc(), rc(), rc(), int'($urandom_range(0, 3)));
                end
                for (int gap = $urandom_range(1, 3); gap > 0; gap--)
                    step(0, 1, 0, ($urandom_range(0, 3) == 0), rc(), rc(), rc(), cm);
            end
        end
        idle(5, 0);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
